// File: rtl/dmem_if.sv
// Request/response channels between the MEM stage (master) and the data-memory responder (slave).
interface dmem_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and read-before-write stores.
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, latency countdown running
// RESP  | response presented, waiting for rsp_ready
module dmem_responder #(
    parameter int WIDTH           = 32,
    parameter int ADDR_REAL_WIDTH = 17,
    parameter int LATENCY         = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus,
    output logic  busy
);
    localparam int         IDX_W    = ADDR_REAL_WIDTH - 2;
    localparam int         DEPTH    = 2 ** IDX_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cnt;
    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic             mis_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;
    logic             rsp_valid_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             commit;
    logic [IDX_W-1:0] req_idx;
    logic             req_mis;
    logic             acc_we;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_mis;
    logic [WIDTH-1:0] acc_wdata;

    assign req_idx = bus.req_addr[ADDR_REAL_WIDTH-1:2];
`ifdef DMEM_MISALIGN_ERR_EN
    assign req_mis = |bus.req_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        acc_we     = we_q;
        acc_idx    = idx_q;
        acc_mis    = mis_q;
        acc_wdata  = wdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    // With single-cycle latency the access uses the live request fields.
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        commit     = 1'b1;
                        acc_we     = bus.req_we;
                        acc_idx    = req_idx;
                        acc_mis    = req_mis;
                        acc_wdata  = bus.req_wdata;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            mis_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= bus.req_we;
                idx_q   <= req_idx;
                mis_q   <= req_mis;
                wdata_q <= bus.req_wdata;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata_q     <= mem[acc_idx];
                err_q       <= acc_mis;
                rsp_valid_q <= 1'b1;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // RAM is never reset; commit is only possible from a live WAIT/IDLE state, so reset drops pending stores.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of accesses plus backpressure and mid-access reset sequences.
module tb_dmem_responder;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[11];

    dmem_if #(.WIDTH(32)) bus();

    dmem_responder #(
        .WIDTH(32),
        .ADDR_REAL_WIDTH(17),
        .LATENCY(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] w40;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        w40 = MIS ? 32'h0000_0055 : 32'h0000_0011;
        vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0002_0004, 32'h1234_5678, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0040, 32'h0000_0055, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'hFFFE_0040, 32'h0,         1'b1, 32'h0000_0055, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0042, 32'h0000_0011, 1'b1, 32'h0000_0055, MIS};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, w40,           1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0043, 32'h0,         1'b1, w40,           MIS};
        vecs[10] = '{1'b1, 32'h0000_0080, 32'h0102_0304, 1'b0, 32'h0,         1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Vector table, rsp_ready held high
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            check($sformatf("vec%0d_req_ready_low", i), 32'(bus.req_ready), 32'd0);
            wait_rsp(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            if (vecs[i].chk)
                check($sformatf("vec%0d_rdata", i), bus.rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(bus.rsp_err), 32'(vecs[i].exp_err));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rsp_done", i), 32'(bus.rsp_valid), 32'd0);
            check($sformatf("vec%0d_req_ready_back", i), 32'(bus.req_ready), 32'd1);
        end

        // Backpressure: response held for 5 cycles
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0040, 32'h0);
        wait_rsp(lat);
        check("bp_latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", c), bus.rsp_rdata, w40);
            check($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
            check($sformatf("bp%0d_busy", c), 32'(busy), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rsp_done", 32'(bus.rsp_valid), 32'd0);
        check("bp_busy_done", 32'(busy), 32'd0);
        check("bp_rdata_kept", bus.rsp_rdata, w40);

        // Reset one cycle after accepting a store: store must be discarded
        issue(1'b1, 32'h0000_0080, 32'hAAAA_5555);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rdata", bus.rsp_rdata, 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h0000_0080, 32'h0);
        wait_rsp(lat);
        check("midrst_load_latency", 32'(lat), 32'd2);
        check("midrst_load_rdata", bus.rsp_rdata, 32'h0102_0304);
        @(posedge clk);
        #1;
        check("midrst_load_done", 32'(bus.rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
